md_unit_iter: RTL



---
 rtl/md_pkg.sv | 44 ++++
 rtl/md_unit_iter_step.sv | 64 ++++++
 rtl/md_unit_iter.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/md_pkg.sv
`default_nettype none
// ============================================================================
// Module      : md_pkg
// Description : Shared encodings and helper predicates for the iterative
//               multiply/divide/accumulate unit.
//               Contents: operation codes, FSM state encoding and the
//               is_signed / is_div / is_acc classification helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package md_pkg;

  typedef enum logic [2:0] {
    MD_MULT  = 3'd0,
    MD_MULTU = 3'd1,
    MD_DIV   = 3'd2,
    MD_DIVU  = 3'd3,
    MD_MADD  = 3'd4,
    MD_MADDU = 3'd5,
    MD_MSUB  = 3'd6,
    MD_MSUBU = 3'd7
  } md_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } md_state_e;

  // Even opcodes are the signed flavours.
  function automatic logic is_signed(input logic [2:0] op);
    return ~op[0];
  endfunction

  function automatic logic is_div(input logic [2:0] op);
    return (op[2:1] == 2'b01);
  endfunction

  // MADD/MADDU/MSUB/MSUBU; op[1] then selects subtract.
  function automatic logic is_acc(input logic [2:0] op);
    return op[2];
  endfunction

endpackage
`default_nettype wire

// File: rtl/md_unit_iter_step.sv
`default_nettype none
// ============================================================================
// Module      : md_iter_step
// Description : Combinational UNROLL-bit iteration step.
//               Multiply: shift-add, {rem,q} holds {partial product, multiplier};
//               the multiplier LSB selects adding i_d, then the pair shifts right.
//               Divide: restoring, q shifts the dividend out MSB-first into rem
//               and quotient bits in LSB-first.
//   i_div        : 1 = divide step, 0 = multiply step
//   i_rem/i_q    : current working registers
//   i_d          : multiplicand (multiply) or divisor (divide) magnitude
//   o_rem/o_q    : working registers after UNROLL bits
// Revision    : 1.0 - initial release
// ============================================================================
module md_iter_step #(
  parameter int WIDTH  = 32,
  parameter int UNROLL = 1
) (
  input  logic             i_div,
  input  logic [WIDTH-1:0] i_rem,
  input  logic [WIDTH-1:0] i_q,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_rem,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] w_rem;
  logic [WIDTH-1:0] w_q;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_trial;
  logic [WIDTH:0]   w_diff;

  always_comb begin
    w_rem   = i_rem;
    w_q     = i_q;
    w_sum   = '0;
    w_trial = '0;
    w_diff  = '0;
    for (int k = 0; k < UNROLL; k++) begin
      if (i_div) begin
        w_trial = {w_rem, w_q[WIDTH-1]};
        w_diff  = w_trial - {1'b0, i_d};
        // rem < divisor keeps trial below 2*divisor, so the top bit of the
        // difference is a clean borrow indicator.
        if (!w_diff[WIDTH]) begin
          w_rem = w_diff[WIDTH-1:0];
          w_q   = {w_q[WIDTH-2:0], 1'b1};
        end else begin
          w_rem = w_trial[WIDTH-1:0];
          w_q   = {w_q[WIDTH-2:0], 1'b0};
        end
      end else begin
        w_sum = {1'b0, w_rem} + (w_q[0] ? {1'b0, i_d} : '0);
        w_q   = {w_sum[0], w_q[WIDTH-1:1]};
        w_rem = w_sum[WIDTH:1];
      end
    end
  end

  assign o_rem = w_rem;
  assign o_q   = w_q;

endmodule
`default_nettype wire

// File: rtl/md_unit_iter.sv
`default_nettype none
// ============================================================================
// Module      : md_unit_iter
// Description : Iterative multiply/divide/accumulate unit owning HI/LO.
//               IDLE -> RUN (WIDTH/UNROLL cycles) -> FIX (sign fix, accumulate,
//               write-back) -> IDLE. Latency WIDTH/UNROLL+1 cycles.
//   clk, reset            : clock, synchronous active-high reset
//   i_start/i_op/i_a/i_b  : launch request and operands (sampled in IDLE)
//   i_cancel              : flush; aborts RUN/FIX without touching HI/LO
//   i_hi_we/i_lo_we/i_wdata : mthi/mtlo writes, honoured only in IDLE
//   o_hi/o_lo             : HI/LO registers
//   o_busy                : operation in progress
//   o_done                : one-cycle pulse when HI/LO take a result
//   o_div_zero            : sticky divide-by-zero flag
// Revision    : 1.0 - initial release
// ============================================================================
module md_unit_iter
  import md_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int UNROLL = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_start,
  input  logic [2:0]       i_op,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_cancel,
  input  logic             i_hi_we,
  input  logic             i_lo_we,
  input  logic [WIDTH-1:0] i_wdata,
  output logic [WIDTH-1:0] o_hi,
  output logic [WIDTH-1:0] o_lo,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_div_zero
);

  localparam int c_ITERS = WIDTH / UNROLL;
  localparam int c_CNT_W = $clog2(c_ITERS + 1);
  localparam logic [c_CNT_W-1:0] c_LAST_CNT = c_CNT_W'(c_ITERS - 1);

  md_state_e          r_state;
  md_state_e          w_next;
  logic               w_launch;
  logic               w_commit;

  logic [2:0]         r_op;
  logic [WIDTH-1:0]   r_a;
  logic               r_sa;
  logic               r_sb;
  logic               r_bz;
  logic [WIDTH-1:0]   r_d;
  logic [WIDTH-1:0]   r_rem;
  logic [WIDTH-1:0]   r_q;
  logic [c_CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic               r_done;
  logic               r_dz;

  logic               w_sa;
  logic               w_sb;
  logic [WIDTH-1:0]   w_mag_a;
  logic [WIDTH-1:0]   w_mag_b;
  logic [WIDTH-1:0]   w_step_rem;
  logic [WIDTH-1:0]   w_step_q;
  logic [2*WIDTH-1:0] w_prod;
  logic [2*WIDTH-1:0] w_prod_fix;
  logic [2*WIDTH-1:0] w_acc;
  logic [2*WIDTH-1:0] w_res;

  // ---------------- FSM ----------------
  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next   = r_state;
    w_launch = 1'b0;
    w_commit = 1'b0;
    case (r_state)
      IDLE: begin
        w_launch = i_start && !i_cancel;
        if (w_launch) w_next = RUN;
      end
      RUN: begin
        if (i_cancel)                 w_next = IDLE;
        else if (r_cnt == c_LAST_CNT) w_next = FIX;
      end
      FIX: begin
        w_commit = !i_cancel;
        w_next   = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // ---------------- operand conditioning ----------------
  assign w_sa    = is_signed(i_op) & i_a[WIDTH-1];
  assign w_sb    = is_signed(i_op) & i_b[WIDTH-1];
  assign w_mag_a = w_sa ? -i_a : i_a;
  assign w_mag_b = w_sb ? -i_b : i_b;

  md_iter_step #(
    .WIDTH  (WIDTH),
    .UNROLL (UNROLL)
  ) u_step (
    .i_div (is_div(r_op)),
    .i_rem (r_rem),
    .i_q   (r_q),
    .i_d   (r_d),
    .o_rem (w_step_rem),
    .o_q   (w_step_q)
  );

  // ---------------- FIX-stage result ----------------
  always_comb begin
    w_prod     = {r_rem, r_q};
    w_prod_fix = (r_sa ^ r_sb) ? -w_prod : w_prod;
    w_acc      = {r_hi, r_lo};
    if (is_div(r_op)) begin
      if (r_bz) w_res = {r_a, {WIDTH{1'b1}}};
      else      w_res = {(r_sa ? -r_rem : r_rem), ((r_sa ^ r_sb) ? -r_q : r_q)};
    end else if (is_acc(r_op)) begin
      w_res = r_op[1] ? (w_acc - w_prod_fix) : (w_acc + w_prod_fix);
    end else begin
      w_res = w_prod_fix;
    end
  end

  // ---------------- datapath ----------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_op   <= '0;
      r_a    <= '0;
      r_sa   <= 1'b0;
      r_sb   <= 1'b0;
      r_bz   <= 1'b0;
      r_d    <= '0;
      r_rem  <= '0;
      r_q    <= '0;
      r_cnt  <= '0;
      r_hi   <= '0;
      r_lo   <= '0;
      r_done <= 1'b0;
      r_dz   <= 1'b0;
    end else begin
      r_done <= w_commit;
      case (r_state)
        IDLE: begin
          if (i_hi_we) r_hi <= i_wdata;
          if (i_lo_we) r_lo <= i_wdata;
          if (w_launch) begin
            r_op  <= i_op;
            r_a   <= i_a;
            r_sa  <= w_sa;
            r_sb  <= w_sb;
            r_bz  <= (i_b == '0);
            r_rem <= '0;
            r_cnt <= '0;
            // Divide shifts the dividend through q; multiply keeps the
            // multiplier in q and adds the multiplicand.
            r_q   <= is_div(i_op) ? w_mag_a : w_mag_b;
            r_d   <= is_div(i_op) ? w_mag_b : w_mag_a;
          end
        end
        RUN: begin
          r_rem <= w_step_rem;
          r_q   <= w_step_q;
          r_cnt <= r_cnt + 1'b1;
        end
        FIX: begin
          if (w_commit) begin
            r_hi <= w_res[2*WIDTH-1:WIDTH];
            r_lo <= w_res[WIDTH-1:0];
            if (is_div(r_op) && r_bz) r_dz <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_hi       = r_hi;
  assign o_lo       = r_lo;
  assign o_busy     = (r_state != IDLE);
  assign o_done     = r_done;
  assign o_div_zero = r_dz;

endmodule
`default_nettype wire
